regfile_scoreboard: RTL

//  Parametrised integer register file with NREAD combinational read ports, one write port,

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_scoreboard_busy.sv | 48 ++++
 rtl/regfile_scoreboard.sv | 84 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and busy-bit priority resolution for the register file / scoreboard slice.
package regfile_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned REG_ZERO   = 0;

    // Next-state action for one busy bit, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        BUSY_RESET,
        BUSY_FLUSH,
        BUSY_STALL,
        BUSY_SET,
        BUSY_CLEAR,
        BUSY_HOLD
    } busy_act_e;

    function automatic busy_act_e busy_act(
        input logic rst,
        input logic flush,
        input logic stall,
        input logic set,
        input logic clr
    );
        if (rst)        return BUSY_RESET;
        else if (flush) return BUSY_FLUSH;
        else if (stall) return BUSY_STALL;
        else if (set)   return BUSY_SET;
        else if (clr)   return BUSY_CLEAR;
        else            return BUSY_HOLD;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// Per-register busy vector tracking long-latency destinations until writeback retires them.
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic                  wb_clr,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_rd,
    output logic [2**ADDR_W-1:0]  busy_vec
);

    localparam int unsigned REGS = 2**ADDR_W;

    logic [REGS-1:0] busy_q;
    logic [REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < REGS; r++) begin
            unique case (busy_act(rst, flush, stall,
                                  iss_valid && (iss_rd == ADDR_W'(r)),
                                  wb_clr && we && (wa == ADDR_W'(r))))
                BUSY_RESET: busy_d[r] = 1'b0;
                BUSY_FLUSH: busy_d[r] = 1'b0;
                BUSY_STALL: busy_d[r] = busy_q[r];
                BUSY_SET:   busy_d[r] = 1'b1;
                BUSY_CLEAR: busy_d[r] = 1'b0;
                default:    busy_d[r] = busy_q[r];
            endcase
        end
        // x0 is never pending, regardless of issue traffic to it
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD combinational read ports, one write port,
// optional writeback bypass and a load-use busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         wa,
    input  logic [DATA_W-1:0]         wd,
    input  logic                      wb_clr,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_rd,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0]          rd_busy,
    output logic [2**ADDR_W-1:0]      busy_vec
);

    localparam int unsigned REGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [REGS];
    logic [DATA_W-1:0] regs_d [REGS];
    logic              wr_fire;

    assign wr_fire = we && !stall;

    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            for (int unsigned r = 0; r < REGS; r++) begin
                regs_d[r] = '0;
            end
        end else if (wr_fire && (wa != ADDR_W'(REG_ZERO))) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    busy_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .we        (we),
        .wa        (wa),
        .wb_clr    (wb_clr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_vec  (busy_vec)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              fwd;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign fwd  = (BYPASS != 0) && wr_fire && (wa == addr);

        // A forwarded retiring write is no longer a hazard for this reader
        always_comb begin
            if (addr == ADDR_W'(REG_ZERO)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = fwd ? wd : regs_q[addr];
                rd_busy[k]                  = (fwd && wb_clr) ? 1'b0 : busy_vec[addr];
            end
        end
    end

endmodule
